// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
//
// Two-entry elastic buffer between instruction fetch and decode. Each fetched
// {pc, instruction} pair is captured under a valid/ready handshake and shown
// to decode with the RV32I opcode/register fields already split out. The
// second entry absorbs one cycle of decode back-pressure, so fetch never
// loses an instruction that has already been accepted. A synchronous flush
// discards everything buffered, and any pair offered in the same cycle, for
// taken branches and jumps.
//
// Optional feature macro: IFID_ILLEGAL_CHECK_EN
//   defined   : each entry carries an illegal-opcode flag computed at push,
//               driven on out_illegal together with the head entry.
//   undefined : no flag storage, out_illegal is tied to 0.
//
// Parameters
//   PC_WIDTH   width of the captured program counter
//   NOP_INSTR  word shown on out_instruction while out_valid=0
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   in_valid         fetch offers a pair this cycle
//   in_ready         buffer can accept a pair this cycle
//   in_pc            pc of the offered instruction
//   in_instruction   offered instruction word
//   flush            discard all buffered and incoming entries
//   out_valid        head entry valid
//   out_ready        decode consumes the head this cycle
//   out_pc           head pc (0 when empty)
//   out_instruction  head instruction (NOP_INSTR when empty)
//   out_opcode .. out_funct7   fixed slices of out_instruction
//   out_illegal      head opcode is outside the RV32I base set
//   occupancy        number of valid entries, 0..2
// ----------------------------------------------------------------------------
//
// state   | meaning
// --------+---------------------------------------------
// S_EMPTY | no entries, out_valid=0, in_ready=1
// S_ONE   | head valid, tail free
// S_FULL  | head and tail valid, in_ready=0
//
module if_id_buffer #(
    parameter int          PC_WIDTH  = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [31:0]         in_instruction,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         out_instruction,
    output logic [6:0]          out_opcode,
    output logic [4:0]          out_rd,
    output logic [2:0]          out_funct3,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [6:0]          out_funct7,
    output logic                out_illegal,
    output logic [1:0]          occupancy
);

    // Encoding equals the entry count so occupancy is a direct copy.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic push;
    logic pop;

    // Storage update strobes from the FSM.
    logic wr_head;   // capture the incoming pair into the head slot
    logic wr_tail;   // capture the incoming pair into the tail slot
    logic mv_tail;   // advance the tail entry into the head slot

    logic [PC_WIDTH-1:0] head_pc_q, tail_pc_q;
    logic [31:0]         head_instr_q, tail_instr_q;

    // Handshake qualifiers come only from registered state, so in_ready has
    // no combinational path from out_ready.
    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign occupancy = state_q;

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and storage strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wr_head = 1'b0;
        wr_tail = 1'b0;
        mv_tail = 1'b0;

        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d = S_ONE;
                        wr_head = 1'b1;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        // Head leaves and the new pair takes its place.
                        state_d = S_ONE;
                        wr_head = 1'b1;
                    end else if (push) begin
                        state_d = S_FULL;
                        wr_tail = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // push cannot occur here since in_ready is low.
                    if (pop) begin
                        state_d = S_ONE;
                        mv_tail = 1'b1;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            head_pc_q    <= '0;
            head_instr_q <= NOP_INSTR;
            tail_pc_q    <= '0;
            tail_instr_q <= NOP_INSTR;
        end else begin
            if (wr_head) begin
                head_pc_q    <= in_pc;
                head_instr_q <= in_instruction;
            end else if (mv_tail) begin
                head_pc_q    <= tail_pc_q;
                head_instr_q <= tail_instr_q;
            end
            if (wr_tail) begin
                tail_pc_q    <= in_pc;
                tail_instr_q <= in_instruction;
            end
        end
    end

`ifdef IFID_ILLEGAL_CHECK_EN
    logic in_illegal;
    logic head_ill_q, tail_ill_q;

    // Opcodes of the RV32I base set; anything else, including compressed
    // encodings (low bits != 2'b11), is flagged.
    always_comb begin
        in_illegal = 1'b1;
        case (in_instruction[6:0])
            7'b0110011,
            7'b0010011,
            7'b0000011,
            7'b0100011,
            7'b1100011,
            7'b1101111,
            7'b1100111,
            7'b0110111,
            7'b0010111,
            7'b1110011,
            7'b0001111: in_illegal = 1'b0;
            default:    in_illegal = 1'b1;
        endcase
        if (in_instruction[1:0] != 2'b11) begin
            in_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ill_q <= 1'b0;
            tail_ill_q <= 1'b0;
        end else begin
            if (wr_head) begin
                head_ill_q <= in_illegal;
            end else if (mv_tail) begin
                head_ill_q <= tail_ill_q;
            end
            if (wr_tail) begin
                tail_ill_q <= in_illegal;
            end
        end
    end

    assign out_illegal = out_valid & head_ill_q;
`else
    assign out_illegal = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output presentation: only the NOP mux is combinational.
    // ------------------------------------------------------------------
    assign out_pc          = out_valid ? head_pc_q    : '0;
    assign out_instruction = out_valid ? head_instr_q : NOP_INSTR;

    assign out_opcode = out_instruction[6:0];
    assign out_rd     = out_instruction[11:7];
    assign out_funct3 = out_instruction[14:12];
    assign out_rs1    = out_instruction[19:15];
    assign out_rs2    = out_instruction[24:20];
    assign out_funct7 = out_instruction[31:25];

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic        out_illegal;
    logic [1:0]  occupancy;

    if_id_buffer #(.PC_WIDTH(32), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instruction(in_instruction),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instruction(out_instruction),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_illegal(out_illegal), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_illegal(input logic [31:0] i);
`ifdef IFID_ILLEGAL_CHECK_EN
        logic known;
        known = (i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111, 7'b1110011, 7'b0001111});
        return (i[1:0] != 2'b11) | ~known;
`else
        return 1'b0 & i[0];
`endif
    endfunction

    // Compare every output against the scoreboard head while the inputs for
    // this cycle are stable, then advance the model by the handshake.
    task automatic check_outputs();
        logic [31:0] ei;
        logic [31:0] ep;
        logic        el;
        if (sb.size() != 0) begin
            ei = sb[0].instr;
            ep = sb[0].pc;
            el = exp_illegal(ei);
        end else begin
            ei = NOP;
            ep = '0;
            el = 1'b0;
        end
        check_eq("occupancy", {30'd0, occupancy}, sb.size());
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        check_eq("out_pc", out_pc, ep);
        check_eq("out_instruction", out_instruction, ei);
        check_eq("out_opcode", {25'd0, out_opcode}, {25'd0, ei[6:0]});
        check_eq("out_rd", {27'd0, out_rd}, {27'd0, ei[11:7]});
        check_eq("out_funct3", {29'd0, out_funct3}, {29'd0, ei[14:12]});
        check_eq("out_rs1", {27'd0, out_rs1}, {27'd0, ei[19:15]});
        check_eq("out_rs2", {27'd0, out_rs2}, {27'd0, ei[24:20]});
        check_eq("out_funct7", {25'd0, out_funct7}, {25'd0, ei[31:25]});
        check_eq("out_illegal", {31'd0, out_illegal}, {31'd0, el});
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        logic mpush;
        logic mpop;
        ent_t e;
        in_valid       = v;
        in_pc          = pc;
        in_instruction = ins;
        out_ready      = ordy;
        flush          = fl;
        @(negedge clk);
        check_outputs();
        mpush = v & (sb.size() < 2) & ~fl;
        mpop  = (sb.size() != 0) & ordy & ~fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (mpop) void'(sb.pop_front());
            if (mpush) begin
                e.pc    = pc;
                e.instr = ins;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        reset     = 1'b1;
        in_valid  = v;
        in_pc     = 32'hDEAD0000;
        in_instruction = 32'h00000033;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_pc = '0;
        in_instruction = '0;
        out_ready = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        do_reset(1'b0);

        // Reset then idle.
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Streaming with decode always ready: one-cycle latency, no bubbles.
        step(1, 32'h00, 32'h00500093, 1, 0);
        check_eq("addi_rd", {27'd0, out_rd}, 32'd1);
        check_eq("addi_rs1", {27'd0, out_rs1}, 32'd0);
        check_eq("addi_funct3", {29'd0, out_funct3}, 32'd0);
        check_eq("addi_opcode", {25'd0, out_opcode}, 32'b0010011);
        step(1, 32'h04, 32'h00208133, 1, 0);
        step(1, 32'h08, 32'h0040A183, 1, 0);
        step(1, 32'h0C, 32'h00312223, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Back-pressure: 0x18 is offered but held until there is room.
        step(1, 32'h10, 32'h00100513, 0, 0);
        step(1, 32'h14, 32'h00200593, 0, 0);
        step(1, 32'h18, 32'h00300613, 0, 0);
        step(1, 32'h18, 32'h00300613, 0, 0);
        step(1, 32'h18, 32'h00300613, 1, 0);
        step(1, 32'h18, 32'h00300613, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // FULL plus flush with a pair offered: nothing survives.
        step(1, 32'h20, 32'h00000033, 0, 0);
        step(1, 32'h24, 32'h00000033, 0, 0);
        step(1, 32'h28, 32'h00000033, 1, 1);
        step(0, 32'h0, 32'h0, 0, 0);

        // ONE with simultaneous push and pop.
        step(1, 32'h30, 32'h00000093, 0, 0);
        step(1, 32'h34, 32'h00100113, 1, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Illegal-opcode flag.
        step(1, 32'h40, 32'hFFFFFFFF, 0, 0);
        step(1, 32'h44, 32'h00000033, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Reset mid-operation discards entries.
        step(1, 32'h50, 32'h00000013, 0, 0);
        step(1, 32'h54, 32'h00000013, 0, 0);
        do_reset(1'b1);
        step(0, 32'h0, 32'h0, 0, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            if ($urandom_range(0, 1) == 1) ins = $urandom();
            else ins = {$urandom_range(0, 32'h1FFFFFF), 7'b0010011};
            step(($urandom_range(0, 3) != 0), $urandom() & 32'hFFFFFFFC, ins,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
